// File: rtl/mips_pkg.sv
// Shared MIPS control constants: opcodes, funct codes, ALU encodings,
// datapath select values and the multi-cycle control state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Operation class handed to the ALU decoder by the FSM
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's operation class and the R-type funct field onto the
// 4-bit ALU opcode, flagging funct codes the datapath cannot execute.
module alu_decoder
  import mips_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       funct_valid
);

  always_comb begin
    alu_control = ALU_ADD;
    funct_valid = 1'b1;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          default: funct_valid = 1'b0;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch, decode,
// execute, memory and writeback, with mem_ready/zero/funct fast paths.
module mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal
);

  state_t  state, next_state, out_state;
  alu_op_t alu_op;
  logic    is_store;
  logic    funct_valid;
  logic    pc_write, branch, ir_wr, mem_wr, reg_wr, ill;

  // The lw/sw split is latched in DECODE so MEMADR never looks at opcode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) is_store <= (opcode == OP_SW);
    end
  end

  assign out_state = rst_n ? state : S_FETCH;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control),
    .funct_valid (funct_valid)
  );

  always_comb begin
    next_state = S_FETCH;
    alu_op     = ALUOP_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PC_ALU;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    ill        = 1'b0;
    case (out_state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        ir_wr      = mem_ready;
        pc_write   = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      ill        = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_wr     = 1'b1;
        next_state = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        ill        = ~funct_valid;
        next_state = funct_valid ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        reg_wr  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: reg_wr = 1'b1;
      S_JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Reset suppresses every side effect on the datapath immediately
  assign pc_en     = rst_n & (pc_write | (branch & zero));
  assign ir_write  = rst_n & ir_wr;
  assign mem_write = rst_n & mem_wr;
  assign reg_write = rst_n & reg_wr;
  assign illegal   = rst_n & ill;

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle main control unit for the MIPS datapath: a Moore-style state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the ALU's 4-bit `alu_control` opcode and the datapath enables, and consumes the ALU `zero` flag for branches. It sits between the instruction register fields and the shared datapath (PC, memory, register file, ALU).

## Interface
- No parameters.
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `opcode` input 6: instr[31:26], from the IR.
- `funct` input 6: instr[5:0], from the IR.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `alu_control` output 4: 0010 add, 0110 sub, 0000 and, 0001 or.
- `alu_src_a` output 1: 0 = PC, 1 = register A.
- `alu_src_b` output 2: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `pc_src` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_en` output 1: PC load enable (`pc_write | (branch & zero)`).
- `iord` output 1: memory address source, 0 = PC, 1 = ALUOut.
- `mem_write` output 1: memory write strobe.
- `ir_write` output 1: IR load enable.
- `reg_dst` output 1: 0 = rt, 1 = rd.
- `mem_to_reg` output 1: 0 = ALUOut, 1 = MDR.
- `reg_write` output 1: register file write enable.
- `illegal` output 1: one-cycle pulse on an unsupported opcode or funct.

## Operation
States and their outputs (any output not listed is 0; `alu_control` defaults to 0010):
- FETCH: `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `pc_src`=00. `ir_write` and `pc_en` follow `mem_ready`. Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE: `alu_src_a`=0, `alu_src_b`=11. Next state by opcode:
  - lw 0x23 / sw 0x2B → MEMADR
  - R-type 0x00 → EXECUTE
  - beq 0x04 → BRANCH
  - addi 0x08 → ADDIEX
  - j 0x02 → JUMP
  - any other opcode → FETCH, with `illegal`=1.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `mem_to_reg`=1, `reg_write`=1, `reg_dst`=0. Goes to FETCH.
- MEMWR: `iord`=1, `mem_write`=1. `mem_write` is held until `mem_ready`, then goes to FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00. `alu_control` from funct: 0x20→0010, 0x22→0110, 0x24→0000, 0x25→0001. Goes to ALUWB. Any other funct → FETCH, with `illegal`=1 and no writeback.
- ALUWB: `reg_dst`=1, `reg_write`=1. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_control`=0110, `pc_src`=01, `pc_en`=`zero`. Goes to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, add. Goes to ADDIWB.
- ADDIWB: `reg_dst`=0, `reg_write`=1. Goes to FETCH.
- JUMP: `pc_src`=10, `pc_en`=1. Goes to FETCH.

Decoding rules:
- `opcode` and `funct` are sampled only in DECODE and EXECUTE.
- The IR holds them stable in all other states.

## Timing
- Reset:
  - `rst_n` sampled low at an edge → state FETCH, regardless of current state. This includes mid-access (MEMRD/MEMWR) and mid-writeback.
  - While `rst_n`=0, all enables (`pc_en`, `ir_write`, `mem_write`, `reg_write`) and `illegal` are forced 0 combinationally. All other outputs take their FETCH values.
- Output timing:
  - All outputs are a function of the state only, with these exceptions: `pc_en`/`ir_write` in FETCH (`mem_ready`), `pc_en` in BRANCH (`zero`), `illegal`, and `alu_control` in EXECUTE (`funct`).
  - These exceptions are combinational, with no added latency.
- Cycle counts with `mem_ready` held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Illegal opcode: 2 cycles. Illegal funct: 3 cycles.
- Memory stalls: each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Enables other than `mem_write` stay 0 during a stall.
- `mem_ready` high outside FETCH/MEMRD/MEMWR is ignored.

## Structure
- Shared package `mips_pkg`:
  - opcode constants and funct constants;
  - `alu_control` encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR);
  - state enum;
  - `alu_src_b` and `pc_src` select constants.
- Sub-module `alu_decoder`: combinational map from (funct, op class) to `alu_control` plus a funct-valid flag. It is instantiated once.
- The FSM is a single state register and next-state/output logic in `mc_control`.

## Test plan
- lw (0x23), `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `reg_write`=1 with `mem_to_reg`=1 in cycle 5 only.
- R-type sub (funct 0x22) → `alu_control`=0110 in cycle 3. `reg_write`=1 with `reg_dst`=1 in cycle 4. Repeat for 0x20/0x24/0x25 → 0010/0000/0001.
- beq:
  - `zero`=1 → `pc_en`=1 with `pc_src`=01 and `alu_control`=0110 in cycle 3;
  - `zero`=0 → `pc_en`=0 throughout cycle 3.
- FETCH with `mem_ready` low for 3 cycles → `ir_write`=`pc_en`=0 for those 3 cycles. Both are 1 in the 4th cycle, then DECODE.
- Illegal cases:
  - opcode 0x3F → `illegal`=1 in cycle 2, FETCH in cycle 3, no write enable ever asserted;
  - funct 0x2A → `illegal`=1 in EXECUTE, no `reg_write`.
- `rst_n` low during MEMWR with `mem_ready`=0 → `mem_write`=0 immediately. FETCH on the next edge. After release, a normal lw completes in 5 cycles.
